excess3_serializer: RTL and testbench

Upstream feeder for the serial excess-3-to-binary converter. It accepts 4-bit BCD digits over a valid/ready handshake and buffers them in a small FIFO. Each digit is converted to excess-3 (digit + 3) and shifted out one bit per clock, LSB first, as a gap-free stream of 4-bit frames. A start-of-frame strobe marks bit 0 of each digit so the downstream converter can stay frame-aligned.

---
 rtl/excess3_serializer.sv | 142 ++++++++++++++
 tb/tb_excess3_serializer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/excess3_serializer.sv
// BCD digit FIFO feeding a gap-free LSB-first excess-3 serial stream.
// sof marks bit 0 of each 4-bit frame for the downstream converter.
module excess3_serializer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               din,
    input  logic                     din_valid,
    output logic                     din_ready,
    input  logic                     err_clr,
    output logic                     out,
    output logic                     out_valid,
    output logic                     sof,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t         state;
    state_t         state_nx;
    logic [3:0]     mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [2:0]     sreg;
    logic [1:0]     bitcnt;
    logic [3:0]     head_e3;
    logic           accept;
    logic           push;
    logic           bad;
    logic           empty;
    logic           load;
    logic           shift;

    assign din_ready = (level != FULL);
    assign empty     = (level == '0);
    assign accept    = din_valid & din_ready;
    assign push      = accept & (din <= 4'd9);
    assign bad       = accept & (din > 4'd9);
    assign head_e3   = mem[rptr] + 4'd3;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (load) rptr <= rptr + 1'b1;
            case ({push, load})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (bad) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!empty) state_nx = SHIFT;
            SHIFT:   if (bitcnt == 2'd3 && empty) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // A new frame loads right after the last bit so frames stay back-to-back.
    always_comb begin
        load  = 1'b0;
        shift = 1'b0;
        case (state)
            IDLE: begin
                load = !empty;
            end
            SHIFT: begin
                load  = (bitcnt == 2'd3) && !empty;
                shift = (bitcnt != 2'd3);
            end
            default: begin
                load  = 1'b0;
                shift = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg      <= '0;
            bitcnt    <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            sof       <= 1'b0;
        end else if (load) begin
            sreg      <= head_e3[3:1];
            bitcnt    <= '0;
            out       <= head_e3[0];
            out_valid <= 1'b1;
            sof       <= 1'b1;
        end else if (shift) begin
            sreg      <= {1'b0, sreg[2:1]};
            bitcnt    <= bitcnt + 1'b1;
            out       <= sreg[0];
            out_valid <= 1'b1;
            sof       <= 1'b0;
        end else begin
            bitcnt    <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            sof       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_excess3_serializer.sv
// Scoreboard bench for excess3_serializer: expected frame bits are
// queued on each accepted digit and compared as the serial stream emerges.
module tb_excess3_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] din = '0;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic       err_clr = 1'b0;
    logic       out;
    logic       out_valid;
    logic       sof;
    logic       err;
    logic [2:0] level;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] exp_q[$];
    logic [3:0] dig_q[$];

    bit         mon_en  = 1'b0;
    bit         gap_chk = 1'b0;
    bit         seen    = 1'b0;
    int         bitpos  = 0;
    logic [3:0] acc     = '0;
    logic [1:0] e_bit;

    excess3_serializer #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .err_clr   (err_clr),
        .out       (out),
        .out_valid (out_valid),
        .sof       (sof),
        .err       (err),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic enq(input logic [3:0] d);
        logic [3:0] e;
        e = d + 4'd3;
        for (int b = 0; b < 4; b++) begin
            exp_q.push_back({b == 0, e[b]});
        end
        dig_q.push_back(d);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [3:0] d);
        bit hs;
        bit done;
        done = 1'b0;
        din = d;
        din_valid = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            hs = din_ready;
            @(posedge clk);
            if (hs) begin
                if (d <= 4'd9) enq(d);
                done = 1'b1;
            end
            @(negedge clk);
        end
        din_valid = 1'b0;
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("extra_bit", 1, 0);
                end else begin
                    e_bit = exp_q.pop_front();
                    check("out_bit", out, e_bit[0]);
                    check("sof", sof, e_bit[1]);
                    if (sof) bitpos = 0;
                    if (bitpos < 4) acc[bitpos] = out;
                    bitpos++;
                    if (bitpos == 4 && dig_q.size() != 0) begin
                        check("decode", acc - 4'd3, dig_q.pop_front());
                    end
                end
                seen = 1'b1;
            end else if (gap_chk && seen && exp_q.size() != 0) begin
                check("frame_gap", 0, 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int maxl;
        bit saw_full;
        bit hs;
        logic [3:0] stream [6];
        stream = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9};

        // Reset and idle
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_state", {out, out_valid, sof, err, level, din_ready},
                  8'b0000_0001);
            @(negedge clk);
        end
        rst = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_state", {out, out_valid, sof, err, level, din_ready},
                  8'b0000_0001);
        end

        // Stream check, back-to-back digits
        gap_chk = 1'b1;
        seen = 1'b0;
        foreach (stream[i]) send(stream[i]);
        drain();
        gap_chk = 1'b0;

        // Backpressure with digit 7 held valid
        gap_chk = 1'b1;
        seen = 1'b0;
        maxl = 0;
        saw_full = 1'b0;
        din = 4'd7;
        din_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            hs = din_ready;
            if (int'(level) > maxl) maxl = int'(level);
            if (!din_ready) saw_full = 1'b1;
            @(posedge clk);
            if (hs) enq(4'd7);
            @(negedge clk);
        end
        din_valid = 1'b0;
        check("bp_max_level", maxl, 4);
        check("bp_ready_low", saw_full, 1);
        drain();
        gap_chk = 1'b0;

        // Illegal digit
        send(4'd12);
        check("err_set", err, 1);
        check("illegal_dropped", level, 0);
        send(4'd1);
        drain();
        check("err_sticky", err, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_cleared", err, 0);
        din = 4'd13;
        din_valid = 1'b1;
        err_clr = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        err_clr = 1'b0;
        check("err_set_wins", err, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_cleared2", err, 0);
        repeat (4) @(negedge clk);

        // Reset between bit 1 and bit 2 of digit 8, two digits queued
        send(4'd8);
        send(4'd5);
        send(4'd6);
        check("mid_level", level, 2);
        check("mid_sof_gone", {out_valid, sof}, 2'b10);
        rst = 1'b0;
        mon_en = 1'b0;
        exp_q.delete();
        dig_q.delete();
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_level", level, 0);
        check("mid_rst_ready", din_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;
        seen = 1'b0;
        repeat (12) @(negedge clk);
        check("post_rst_quiet", out_valid, 0);
        send(4'd4);
        drain();

        // Wrap-around at a moderate pace
        for (int d = 0; d < 10; d++) begin
            send(4'(d));
            check("wrap_level_max", level <= 3'd3, 1);
            repeat (2) @(negedge clk);
        end
        drain();

        check("final_queue", exp_q.size() + dig_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
